simplez_core: RTL and testbench

//  Parametrised SIMPLEZ CPU core implementing the full 8-opcode set (ST LD ADD BR BZ CLR DEC HALT).
//  It talks to external memory over a ready handshake, so wait states are supported.
//  A memory-mapped LED output register is built in. Sits between the board top and the memory/peripheral fabric.

---
 rtl/simplez_pkg.sv | 39 +++
 rtl/simplez_alu.sv | 26 ++
 rtl/simplez_core.sv | 176 +++++++++++++++++
 tb/tb_simplez_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_pkg.sv
// simplez_pkg: shared opcode, FSM-state and ALU-operation encodings for the
// SIMPLEZ core and its ALU.
package simplez_pkg;

    // Instruction opcode, taken from the top three bits of RI
    typedef enum logic [2:0] {
        OP_ST   = 3'd0,
        OP_LD   = 3'd1,
        OP_ADD  = 3'd2,
        OP_BR   = 3'd3,
        OP_BZ   = 3'd4,
        OP_CLR  = 3'd5,
        OP_DEC  = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    // Controller states
    typedef enum logic [2:0] {
        S_INI    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // Operations the accumulator ALU can perform
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_DEC  = 2'd2,
        ALU_ZERO = 2'd3
    } alu_op_e;

    // Opcodes that need a second bus access after decode
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_ST) || (op == OP_LD) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/simplez_alu.sv
// simplez_alu: purely combinational accumulator ALU. Results wrap modulo
// 2^DATAW; carries and borrows are discarded.
module simplez_alu
    import simplez_pkg::*;
#(
    parameter int DATAW = 12
) (
    input  alu_op_e          i_op,
    input  logic [DATAW-1:0] i_ac,
    input  logic [DATAW-1:0] i_operand,
    output logic [DATAW-1:0] o_res
);

    // Select the accumulator's next value for the requested operation
    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_PASS: o_res = i_operand;
            ALU_ADD:  o_res = i_ac + i_operand;
            ALU_DEC:  o_res = i_ac - DATAW'(1);
            ALU_ZERO: o_res = '0;
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/simplez_core.sv
// simplez_core: SIMPLEZ CPU (ST LD ADD BR BZ CLR DEC HALT) with a ready
// handshake to external memory and a memory-mapped LED register.
// Optional feature macro: SIMPLEZ_INPORT_EN adds a registered input port
// that LD/ADD read in a single cycle at INPORT_ADDR without a bus access.
module simplez_core
    import simplez_pkg::*;
#(
    parameter int               DATAW       = 12,
    parameter int               ADDRW       = 9,
    parameter int               LEDW        = 4,
    parameter logic [ADDRW-1:0] LEDS_ADDR   = 9'o100
`ifdef SIMPLEZ_INPORT_EN
    ,
    parameter logic [ADDRW-1:0] INPORT_ADDR = 9'o101
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ready,
`ifdef SIMPLEZ_INPORT_EN
    input  logic [DATAW-1:0] inport,
`endif
    output logic [LEDW-1:0]  leds,
    output logic             stop
);

    state_e           r_state;
    logic [ADDRW-1:0] r_pc;
    logic [DATAW-1:0] r_ac;
    logic [DATAW-1:0] r_ri;
    logic [LEDW-1:0]  r_leds;
    logic             r_stop;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic [ADDRW-1:0] r_mem_addr;

    opcode_e          w_op;
    logic [ADDRW-1:0] w_cd;
    logic             w_zero;
    logic             w_is_mem;
    logic             w_inport_hit;
    logic [DATAW-1:0] w_operand;
    logic [ADDRW-1:0] w_next_pc;
    alu_op_e          w_alu_op;
    logic [DATAW-1:0] w_alu_res;

    assign w_op      = opcode_e'(r_ri[DATAW-1:DATAW-3]);
    assign w_cd      = r_ri[ADDRW-1:0];
    assign w_zero    = (r_ac == '0);
    assign w_is_mem  = is_mem_op(w_op);
    // Only BR and a BZ that sees AC==0 redirect the program counter
    assign w_next_pc = ((w_op == OP_BR) || ((w_op == OP_BZ) && w_zero)) ? w_cd : r_pc;

`ifdef SIMPLEZ_INPORT_EN
    logic [DATAW-1:0] r_inport;

    // Sample the input port every cycle; reads use this registered copy
    always_ff @(posedge clk) begin
        r_inport <= inport;
    end

    assign w_inport_hit = (w_cd == INPORT_ADDR) && ((w_op == OP_LD) || (w_op == OP_ADD));
    assign w_operand    = w_inport_hit ? r_inport : mem_rdata;
`else
    assign w_inport_hit = 1'b0;
    assign w_operand    = mem_rdata;
`endif

    // Map the current opcode to the ALU operation that produces the next AC
    always_comb begin
        w_alu_op = ALU_PASS;
        case (w_op)
            OP_ADD:  w_alu_op = ALU_ADD;
            OP_DEC:  w_alu_op = ALU_DEC;
            OP_CLR:  w_alu_op = ALU_ZERO;
            default: w_alu_op = ALU_PASS;
        endcase
    end

    simplez_alu #(
        .DATAW (DATAW)
    ) u_alu (
        .i_op      (w_alu_op),
        .i_ac      (r_ac),
        .i_operand (w_operand),
        .o_res     (w_alu_res)
    );

    // Controller: sequences fetch/decode/memory phases and drives the bus
    // from registers so address and strobes are steady while a request waits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_INI;
            r_pc       <= '0;
            r_ac       <= '0;
            r_ri       <= '0;
            r_leds     <= '0;
            r_stop     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_INI: begin
                    r_state    <= S_FETCH;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_pc;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ri     <= mem_rdata;
                        r_pc     <= r_pc + ADDRW'(1);
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                        r_stop  <= 1'b1;
                    end else if (w_is_mem) begin
                        r_state    <= S_MEM;
                        r_mem_addr <= w_cd;
                        r_mem_rd   <= (w_op != OP_ST) && !w_inport_hit;
                        r_mem_wr   <= (w_op == OP_ST);
                    end else begin
                        // Register-only opcodes finish here and refetch at once
                        r_state    <= S_FETCH;
                        r_pc       <= w_next_pc;
                        r_mem_addr <= w_next_pc;
                        r_mem_rd   <= 1'b1;
                        if ((w_op == OP_CLR) || (w_op == OP_DEC)) begin
                            r_ac <= w_alu_res;
                        end
                    end
                end
                S_MEM: begin
                    if (w_inport_hit || mem_ready) begin
                        if (w_op == OP_ST) begin
                            if (w_cd == LEDS_ADDR) begin
                                r_leds <= r_ac[LEDW-1:0];
                            end
                        end else begin
                            r_ac <= w_alu_res;
                        end
                        r_mem_wr   <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state  <= S_INI;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_ac;
    assign leds      = r_leds;
    assign stop      = r_stop;

endmodule

// File: tb/tb_simplez_core.sv
// tb_simplez_core: directed programs with hand-computed cycle-by-cycle bus
// traces, memory contents, LED and stop values for simplez_core.
module tb_simplez_core;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic [11:0] inport = 12'o0042;
    logic [3:0]  leds;
    logic        stop;

    int n_vec = 0;
    int n_mis = 0;

    logic [11:0] mem [512];
    logic        ld_en = 1'b0;
    logic        ld_clr = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [11:0] ld_data = '0;

    // expected {rd, wr, addr (0 when idle)} and mem_ready for each cycle
    logic [10:0] expv [64];
    logic        rdy  [64];

    simplez_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
`ifdef SIMPLEZ_INPORT_EN
        .inport    (inport),
`endif
        .leds      (leds),
        .stop      (stop)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Single process owns the memory array: DUT writes and bench loading
    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (mem_wr && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0o, expected %0o", tag, act, req);
        end
    endtask

    function automatic logic [10:0] R(input logic [8:0] a);
        return {2'b10, a};
    endfunction

    function automatic logic [10:0] W(input logic [8:0] a);
        return {2'b01, a};
    endfunction

    task automatic poke(input logic [8:0] a, input logic [11:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic clear_all();
        rstn   = 1'b0;
        ld_clr = 1'b1;
        @(posedge clk);
        #1 ld_clr = 1'b0;
        for (int c = 0; c < 64; c++) begin
            expv[c] = '0;
            rdy[c]  = 1'b1;
        end
    endtask

    task automatic do_reset(input string name);
        rstn      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk({name, " rst rd/wr"}, {mem_rd, mem_wr}, 2'b00);
        chk({name, " rst addr"}, mem_addr, 9'o000);
        chk({name, " rst leds/stop"}, {leds, stop}, 5'b0);
        rstn = 1'b1;
        #1;
        chk({name, " c0 INI rd"}, {mem_rd, mem_wr}, 2'b00);
    endtask

    task automatic run_prog(input string name, input int n);
        logic [10:0] act;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            mem_ready = rdy[c];
            #1;
            act = {mem_rd, mem_wr, (mem_rd || mem_wr) ? mem_addr : 9'o000};
            chk($sformatf("%s c%0d bus", name, c), act, expv[c]);
        end
    endtask

    initial begin
        int busy;

        // ---------------- program 1: zero-wait full opcode walk ----------------
        clear_all();
        poke(9'o000, 12'o1020); poke(9'o001, 12'o2021); poke(9'o002, 12'o0022);
        poke(9'o003, 12'o5000); poke(9'o004, 12'o4030);
        poke(9'o030, 12'o6000); poke(9'o031, 12'o4040); poke(9'o032, 12'o0023);
        poke(9'o033, 12'o1024); poke(9'o034, 12'o0100); poke(9'o035, 12'o7000);
        poke(9'o040, 12'o7000);
        poke(9'o020, 12'o0005); poke(9'o021, 12'o7774); poke(9'o024, 12'o0013);
        expv[1]  = R(9'o000); expv[3]  = R(9'o020); expv[4]  = R(9'o001);
        expv[6]  = R(9'o021); expv[7]  = R(9'o002); expv[9]  = W(9'o022);
        expv[10] = R(9'o003); expv[12] = R(9'o004); expv[14] = R(9'o030);
        expv[16] = R(9'o031); expv[18] = R(9'o032); expv[20] = W(9'o023);
        expv[21] = R(9'o033); expv[23] = R(9'o024); expv[24] = R(9'o034);
        expv[26] = W(9'o100); expv[27] = R(9'o035);
        do_reset("p1");
        run_prog("p1", 26);
        chk("p1 leds before ST completes", leds, 4'b0000);
        run_prog_tail: begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("p1 c27 bus", {mem_rd, mem_wr, mem_addr}, R(9'o035));
            chk("p1 leds after ST 0100", leds, 4'b1011);
        end
        @(posedge clk); @(negedge clk); #1;
        chk("p1 stop in decode of HALT", stop, 1'b0);
        @(posedge clk); @(negedge clk); #1;
        chk("p1 stop halted", stop, 1'b1);
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_rd || mem_wr) busy++;
            @(negedge clk); #1;
        end
        chk("p1 no bus activity while halted", busy, 0);
        chk("p1 stop held", stop, 1'b1);
        chk("p1 mem[022] LD+ADD carry dropped", mem[9'o022], 12'o0001);
        chk("p1 mem[023] DEC from 0", mem[9'o023], 12'o7777);
        chk("p1 mem[0100] LED store", mem[9'o100], 12'o0013);

        // ---------------- program 2: wait states on LD and ADD ----------------
        clear_all();
        poke(9'o000, 12'o1020); poke(9'o001, 12'o2020); poke(9'o002, 12'o0022);
        poke(9'o003, 12'o7000); poke(9'o020, 12'o0005);
        expv[1]  = R(9'o000);
        expv[3]  = R(9'o020); rdy[3]  = 1'b0;
        expv[4]  = R(9'o020); rdy[4]  = 1'b0;
        expv[5]  = R(9'o020); rdy[5]  = 1'b0;
        expv[6]  = R(9'o020);
        expv[7]  = R(9'o001);
        expv[9]  = R(9'o020); rdy[9]  = 1'b0;
        expv[10] = R(9'o020); rdy[10] = 1'b0;
        expv[11] = R(9'o020);
        expv[12] = R(9'o002);
        expv[14] = W(9'o022);
        expv[15] = R(9'o003);
        do_reset("p2");
        run_prog("p2", 17);
        chk("p2 stop", stop, 1'b1);
        chk("p2 mem[022] AC updated once per access", mem[9'o022], 12'o0012);

        // ---------------- program 3: reset during a pending write ----------------
        clear_all();
        poke(9'o000, 12'o0022); poke(9'o001, 12'o7000); poke(9'o022, 12'o1234);
        expv[1] = R(9'o000);
        expv[3] = W(9'o022); rdy[3] = 1'b0;
        do_reset("p3");
        run_prog("p3", 3);
        rstn = 1'b0;
        #1;
        chk("p3 async reset drops mem_wr", {mem_rd, mem_wr}, 2'b00);
        chk("p3 async reset addr", mem_addr, 9'o000);
        expv[3] = '0;
        do_reset("p3r");
        run_prog("p3r", 1);
        chk("p3 abandoned write left memory", mem[9'o022], 12'o1234);

        // ---------------- program 4: input-port address ----------------
        clear_all();
        poke(9'o000, 12'o1101); poke(9'o001, 12'o0022); poke(9'o002, 12'o7000);
        poke(9'o101, 12'o0777);
        expv[1] = R(9'o000);
`ifdef SIMPLEZ_INPORT_EN
        rdy[3]  = 1'b0;
        expv[4] = R(9'o001);
        expv[6] = W(9'o022);
        expv[7] = R(9'o002);
        do_reset("p4");
        run_prog("p4", 9);
        chk("p4 stop", stop, 1'b1);
        chk("p4 LD from inport", mem[9'o022], 12'o0042);
`else
        expv[3] = R(9'o101);
        expv[4] = R(9'o001);
        expv[6] = W(9'o022);
        expv[7] = R(9'o002);
        do_reset("p4");
        run_prog("p4", 9);
        chk("p4 stop", stop, 1'b1);
        chk("p4 LD from ordinary memory", mem[9'o022], 12'o0777);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
